osc_bank: RTL and testbench
===========================

// Module: osc_bank
// PURPOSE
//   Parametrised bank of VOICES independent phase-counter oscillators.
//   Each voice has runtime-programmable period (divider) and waveform mode (sawtooth or triangle).
//   Voices advance only on a shared sample_tick, so the bank runs at the audio sample rate, not clk.
//   Adds per-voice enable, hard-sync and wrap pulses. Output counts feed the waveform/mixer stage.
// PARAMETERS
//   WIDTH   16  bits per voice counter and divider
//   VOICES  4   number of independent oscillator voices (>=1)
//   VW      $clog2(VOICES) (min 1), localparam, cfg_voice width
// PORTS
//   clk          in   1              system clock, rising edge
//   n_rst        in   1              reset: asynchronous, active-low
//   sample_tick  in   1              1-cycle strobe; enabled voices advance one step
//   cfg_we       in   1              config write strobe
//   cfg_voice    in   VW             voice index targeted by write
//   cfg_divider  in   WIDTH          new divider (period control) for cfg_voice
//   cfg_mode     in   1              new mode: 0 = sawtooth, 1 = triangle
//   voice_en     in   VOICES         per-voice run enable (level)
//   sync         in   VOICES         per-voice hard sync (1-cycle strobe)
//   count        out  VOICES*WIDTH   voice v count at [v*WIDTH +: WIDTH]
//   wrap         out  VOICES         per-voice 1-cycle period-boundary pulse
// BEHAVIOUR
//   Reset (n_rst=0, async):
//     - Per voice: divider_r=0, mode_r=0, count=0, dir=up, wrap=0.
//   Per voice, per clk:
//     - Step occurs when sample_tick && voice_en[v] && !sync[v].
//   Sawtooth step (mode_r=0):
//     - count>=divider_r: count<=1, wrap event. Otherwise count<=count+1.
//     - divider_r=0 or 1: count sits at 1, wrap every step.
//     - D>=1: period is D steps.
//   Triangle step (mode_r=1):
//     - dir=up, count>=divider_r: dir<=down, count<=count-1.
//     - dir=up otherwise: count<=count+1.
//     - dir=down, count<=1: dir<=up, count<=count+1, wrap event.
//     - dir=down otherwise: count<=count-1.
//     - D=4 from reset gives 0,1,2,3,4,3,2,1,2,3,... Period is 2*(D-1) steps for D>=2.
//   Width and arithmetic:
//     - Unsigned arithmetic, no overflow: count never exceeds max(divider_r, 2^WIDTH-1).
//     - If divider_r is lowered below count: saw wraps to 1 on the next step; triangle turns down next step.
//   wrap:
//     - Registered; wrap[v]=1 for exactly the cycle after a step with a wrap event, else 0.
//   No step (tick low or voice disabled):
//     - count and dir hold; wrap=0.
//   Sync:
//     - sync[v]=1: count<=0, dir<=up, wrap<=0. Sync beats tick in the same cycle.
//   Config write:
//     - cfg_we=1, cfg_voice<VOICES: divider_r/mode_r of that voice update at the next edge.
//     - cfg_voice>=VOICES: write ignored.
//     - Write and step in the same cycle: the step uses the old divider_r/mode_r.
//     - Write that changes mode_r also forces count<=0, dir<=up, overriding the step.
//     - Same-mode write leaves count and dir untouched.
//   Independence:
//     - Voices share only sample_tick and the cfg bus; there is no cross-voice interaction.
//   Reset mid-operation:
//     - All state and outputs return to reset values immediately, with no clock needed.
// TESTING
//   1. Saw, D=3, en=1, tick every cycle:
//      - count 0,1,2,3,1,2,3,1.
//      - wrap high in the cycle after each 3->1 step.
//   2. Triangle, D=4:
//      - count 0,1,2,3,4,3,2,1,2.
//      - Single wrap pulse after the 1->2 turn.
//      - tick every 3rd cycle: count changes only after ticks.
//   3. voice_en[1]=0 while voice 0 runs:
//      - voice 1 count frozen, wrap[1]=0.
//      - Re-enable: voice 1 resumes from the held value.
//   4. sync[0] asserted with tick at count=2 (saw, D=5):
//      - count=0 next cycle, no wrap.
//      - Then 1,2,...
//   5. Write D=2 to voice 0 (count=4, saw) in the same cycle as a tick:
//      - Old D used for that step, giving count=5.
//      - Next tick: count=1 with wrap.
//      - Mode-change write: count=0.
//   6. Assert n_rst mid-count, asynchronously between clock edges:
//      - count/wrap go to 0 immediately.
//      - Write to cfg_voice=VOICES: no state change.

Source files
------------

// File: rtl/osc_bank_if.sv
// Oscillator bank bus: shared tick, config write port, per-voice controls and outputs.
// The master drives stimulus and config; the slave (the bank) returns counts and wrap pulses.
interface osc_bank_if #(
   parameter int WIDTH  = 16,
   parameter int VOICES = 4
);
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

   logic                    sample_tick;
   logic                    cfg_we;
   logic [VW-1:0]           cfg_voice;
   logic [WIDTH-1:0]        cfg_divider;
   logic                    cfg_mode;
   logic [VOICES-1:0]       voice_en;
   logic [VOICES-1:0]       sync;
   logic [VOICES*WIDTH-1:0] count;
   logic [VOICES-1:0]       wrap;

   modport master (
      output sample_tick, cfg_we, cfg_voice, cfg_divider, cfg_mode, voice_en, sync,
      input  count, wrap
   );

   modport slave (
      input  sample_tick, cfg_we, cfg_voice, cfg_divider, cfg_mode, voice_en, sync,
      output count, wrap
   );
endinterface

// File: rtl/osc_bank.sv
// Bank of VOICES phase-counter oscillators (sawtooth/triangle) stepping on sample_tick.
// Outputs are registered: count/wrap reflect the step taken at the previous clock edge.
module osc_bank #(
   parameter int WIDTH  = 16,
   parameter int VOICES = 4
) (
   input  logic      clk,
   input  logic      n_rst,
   osc_bank_if.slave bus
);
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

   genvar v;
   generate
      for (v = 0; v < VOICES; v++) begin : g_voice
         logic [WIDTH-1:0] r_div;
         logic             r_mode;
         logic [WIDTH-1:0] r_count;
         logic             r_dir;      // 0 = counting up, 1 = counting down
         logic             r_wrap;

         logic             w_wr;
         logic             w_mode_chg;
         logic             w_step;
         logic [WIDTH-1:0] w_cnt_nxt;
         logic             w_dir_nxt;
         logic             w_wrap_nxt;

         // Out-of-range voice indices match no generate slot, so such writes fall away.
         assign w_wr       = bus.cfg_we && (bus.cfg_voice == VW'(v));
         assign w_mode_chg = w_wr && (bus.cfg_mode != r_mode);
         assign w_step     = bus.sample_tick && bus.voice_en[v] && !bus.sync[v];

         always_comb begin
            w_cnt_nxt  = r_count;
            w_dir_nxt  = r_dir;
            w_wrap_nxt = 1'b0;
            if (bus.sync[v] || w_mode_chg) begin
               w_cnt_nxt = '0;
               w_dir_nxt = 1'b0;
            end else if (w_step) begin
               if (!r_mode) begin
                  if (r_count >= r_div) begin
                     w_cnt_nxt  = WIDTH'(1);
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt = r_count + WIDTH'(1);
                  end
               end else if (!r_dir) begin
                  if (r_count >= r_div) begin
                     w_dir_nxt = 1'b1;
                     // Turning at zero (divider 0) must not underflow.
                     w_cnt_nxt = (r_count == '0) ? '0 : r_count - WIDTH'(1);
                  end else begin
                     w_cnt_nxt = r_count + WIDTH'(1);
                  end
               end else begin
                  if (r_count <= WIDTH'(1)) begin
                     w_dir_nxt  = 1'b0;
                     w_cnt_nxt  = r_count + WIDTH'(1);
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt = r_count - WIDTH'(1);
                  end
               end
            end
         end

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               r_div   <= '0;
               r_mode  <= 1'b0;
               r_count <= '0;
               r_dir   <= 1'b0;
               r_wrap  <= 1'b0;
            end else begin
               if (w_wr) begin
                  r_div  <= bus.cfg_divider;
                  r_mode <= bus.cfg_mode;
               end
               r_count <= w_cnt_nxt;
               r_dir   <= w_dir_nxt;
               r_wrap  <= w_wrap_nxt;
            end
         end

         assign bus.count[v*WIDTH +: WIDTH] = r_count;
         assign bus.wrap[v]                 = r_wrap;
      end
   endgenerate
endmodule

// File: tb/tb_osc_bank.sv
// Directed bench for osc_bank: a vector table of per-cycle stimulus with expected counts/wrap,
// plus hand-written reset sequences. Three voices so an out-of-range cfg_voice is representable.
module tb_osc_bank;
   localparam int WIDTH  = 16;
   localparam int VOICES = 3;

   typedef struct {
      logic        tick;
      logic [2:0]  en;
      logic [2:0]  sync;
      logic        we;
      logic [1:0]  voice;
      logic [15:0] div;
      logic        mode;
      logic [15:0] c0;
      logic [15:0] c1;
      logic [2:0]  wrap;
   } vec_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   osc_bank_if #(.WIDTH(WIDTH), .VOICES(VOICES)) bus ();

   osc_bank #(.WIDTH(WIDTH), .VOICES(VOICES)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic add(input logic tick, input logic [2:0] en, input logic [2:0] sy,
                      input logic we, input logic [1:0] vo, input logic [15:0] dv,
                      input logic md, input logic [15:0] c0, input logic [15:0] c1,
                      input logic [2:0] wr);
      vec_t t;
      t.tick = tick; t.en = en; t.sync = sy; t.we = we; t.voice = vo;
      t.div = dv; t.mode = md; t.c0 = c0; t.c1 = c1; t.wrap = wr;
      vecs.push_back(t);
   endtask

   task automatic drive(input vec_t t);
      bus.sample_tick = t.tick;
      bus.voice_en    = t.en;
      bus.sync        = t.sync;
      bus.cfg_we      = t.we;
      bus.cfg_voice   = t.voice;
      bus.cfg_divider = t.div;
      bus.cfg_mode    = t.mode;
   endtask

   task automatic check(input string name, input logic [47:0] exp_cnt, input logic [2:0] exp_wrap);
      n_cmp++;
      if (bus.count !== exp_cnt) begin
         n_bad++;
         $display("FAIL %s count: got %h, want %h", name, bus.count, exp_cnt);
      end
      n_cmp++;
      if (bus.wrap !== exp_wrap) begin
         n_bad++;
         $display("FAIL %s wrap: got %b, want %b", name, bus.wrap, exp_wrap);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vec_t idle;
      idle = '{tick: 1'b0, en: 3'b000, sync: 3'b000, we: 1'b0, voice: 2'd0,
               div: 16'd0, mode: 1'b0, c0: 16'd0, c1: 16'd0, wrap: 3'b000};

      // Config: voice0 saw D=3, voice1 saw D=5 (same-mode writes, counts stay 0)
      add(0, 3'b011, 0, 1, 0, 3, 0,  0, 0, 3'b000);
      add(0, 3'b011, 0, 1, 1, 5, 0,  0, 0, 3'b000);
      // Saw run, tick every cycle
      add(1, 3'b011, 0, 0, 0, 0, 0,  1, 1, 3'b000);
      add(1, 3'b011, 0, 0, 0, 0, 0,  2, 2, 3'b000);
      add(1, 3'b011, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      add(1, 3'b011, 0, 0, 0, 0, 0,  1, 4, 3'b001);
      add(1, 3'b011, 0, 0, 0, 0, 0,  2, 5, 3'b000);
      add(1, 3'b011, 0, 0, 0, 0, 0,  3, 1, 3'b010);
      add(1, 3'b011, 0, 0, 0, 0, 0,  1, 2, 3'b001);
      // Voice1 disabled: frozen at 2
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 2, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  3, 2, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 2, 3'b001);
      add(1, 3'b011, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      add(0, 3'b011, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      // Voice0 -> triangle D=4 (mode change clears count)
      add(0, 3'b001, 0, 1, 0, 4, 1,  0, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  4, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b001);
      add(1, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      // Tick every 3rd cycle
      add(0, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      add(0, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  4, 3, 3'b000);
      add(0, 3'b001, 0, 0, 0, 0, 0,  4, 3, 3'b000);
      add(0, 3'b001, 0, 0, 0, 0, 0,  4, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      // Voice0 -> saw D=5, sync at count 2 together with tick
      add(0, 3'b001, 0, 1, 0, 5, 0,  0, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      add(1, 3'b001, 3'b001, 0, 0, 0, 0, 0, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  3, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  4, 3, 3'b000);
      // Write D=2 with tick: old D=5 used, then wrap on next tick
      add(1, 3'b001, 0, 1, 0, 2, 0,  5, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b001);
      // Mode-change write with tick overrides the step
      add(1, 3'b001, 0, 1, 0, 2, 1,  0, 3, 3'b000);
      // Write to nonexistent voice 3: ignored
      add(0, 3'b001, 0, 1, 3, 7, 0,  0, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  1, 3, 3'b000);
      add(1, 3'b001, 0, 0, 0, 0, 0,  2, 3, 3'b001);
      // Same-mode write D=9 to running voice1: count kept, old D used this step
      add(1, 3'b011, 0, 1, 1, 9, 0,  1, 4, 3'b000);
      add(1, 3'b011, 0, 0, 0, 0, 0,  2, 5, 3'b001);
      add(1, 3'b011, 0, 0, 0, 0, 0,  1, 6, 3'b000);
      add(1, 3'b011, 0, 0, 0, 0, 0,  2, 7, 3'b001);

      // Reset state
      drive(idle);
      n_rst = 1'b0;
      cyc();
      check("reset", 48'd0, 3'b000);
      n_rst = 1'b1;
      cyc();
      check("post_reset_idle", 48'd0, 3'b000);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         cyc();
         check($sformatf("vec%0d", i), {16'd0, vecs[i].c1, vecs[i].c0}, vecs[i].wrap);
      end

      // Asynchronous reset between edges while counts are nonzero and wrap is high
      drive(idle);
      #2 n_rst = 1'b0;
      #1 check("async_reset", 48'd0, 3'b000);
      bus.sample_tick = 1'b1;
      bus.voice_en    = 3'b111;
      cyc();
      check("held_in_reset", 48'd0, 3'b000);
      n_rst = 1'b1;
      // Divider cleared to 0 in saw mode: count sits at 1 with wrap every step
      bus.voice_en = 3'b001;
      cyc();
      check("div0_step1", {32'd0, 16'd1}, 3'b001);
      cyc();
      check("div0_step2", {32'd0, 16'd1}, 3'b001);
      bus.sample_tick = 1'b0;
      cyc();
      check("div0_idle", {32'd0, 16'd1}, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
